// File: rtl/corexy_pkg.sv
// Shared types for the CoreXY move sequencer: FSM states, step word layout
// and the queued move record.
package corexy_pkg;

  localparam int STEP_W  = 32;
  localparam int DIR_BIT = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_RUN,
    S_RUN,
    S_RELEASE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [STEP_W-1:0] steps_1;
    logic [STEP_W-1:0] speed_1;
    logic [STEP_W-1:0] steps_2;
    logic [STEP_W-1:0] speed_2;
  } move_t;

  // True when the count field of a step word (direction bit excluded) is zero.
  function automatic logic count_is_zero(input logic [DIR_BIT-1:0] count_field);
    return (count_field == '0);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Move queue: power-of-two FIFO of move records with synchronous flush.
// count_nxt is exported so the owner can register flags that depend on it.
module move_fifo
  import corexy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  move_t                    push_data,
  output move_t                    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  move_t            mem [DEPTH];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/corexy_move_sequencer.sv
// Feeds queued CoreXY moves to a two-axis pulse generator, handles start
// timeout, endstop stops with residual capture, abort and fault recovery.
module corexy_move_sequencer
  import corexy_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_steps_1,
  input  logic [31:0]            cmd_speed_1,
  input  logic [31:0]            cmd_steps_2,
  input  logic [31:0]            cmd_speed_2,
  input  logic                   abort,
  input  logic                   clear_fault,
  output logic [31:0]            stepper_step_in_1,
  output logic [31:0]            stepper_step_in_2,
  output logic [31:0]            stepper_speed_1,
  output logic [31:0]            stepper_speed_2,
  output logic                   start_driving,
  input  logic                   steppers_driving,
  input  logic [31:0]            stepper_step_out_1,
  input  logic [31:0]            stepper_step_out_2,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   move_done,
  output logic                   fault,
  output logic [31:0]            residual_1,
  output logic [31:0]            residual_2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             push;
  logic             pop;
  logic             flush;
  logic             load;
  logic             done;
  logic             latch_res;
  logic             empty;
  logic [CNT_W-1:0] count_nxt;
  move_t            head;
  move_t            cmd_move;

  // Command handshake: a move transfers on every clk edge where
  // cmd_valid && cmd_ready; cmd_ready is registered and never looks at
  // cmd_valid. abort on the same edge wins and the offered move is dropped.
  assign push     = cmd_valid && cmd_ready && !abort;
  assign cmd_move = {cmd_steps_1, cmd_speed_1, cmd_steps_2, cmd_speed_2};

  move_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (cmd_move),
    .head      (head),
    .count     (queue_count),
    .count_nxt (count_nxt),
    .empty     (empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    flush     = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    latch_res = 1'b0;
    if (abort && state != S_HALT) begin
      flush = 1'b1;
      if (state != S_IDLE) begin
        latch_res = 1'b1;
        state_nxt = S_HALT;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) state_nxt = S_LOAD;
        end
        S_LOAD: begin
          pop  = 1'b1;
          load = 1'b1;
          // A move with nothing to step on either axis never wakes the generator.
          if (count_is_zero(head.steps_1[DIR_BIT-1:0]) &&
              count_is_zero(head.steps_2[DIR_BIT-1:0])) begin
            done      = 1'b1;
            state_nxt = S_RELEASE;
          end else begin
            state_nxt = S_START;
          end
        end
        S_START: begin
          state_nxt = S_WAIT_RUN;
        end
        S_WAIT_RUN: begin
          if (steppers_driving) begin
            state_nxt = S_RUN;
          end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
            done      = 1'b1;
            state_nxt = S_RELEASE;
          end
        end
        S_RUN: begin
          if (!steppers_driving) begin
            if (count_is_zero(stepper_step_out_1[DIR_BIT-1:0]) &&
                count_is_zero(stepper_step_out_2[DIR_BIT-1:0])) begin
              done      = 1'b1;
              state_nxt = S_RELEASE;
            end else begin
              // Stopped short: an endstop fired, keep what was left.
              latch_res = 1'b1;
              flush     = 1'b1;
              state_nxt = S_HALT;
            end
          end
        end
        S_RELEASE: begin
          state_nxt = empty ? S_IDLE : S_LOAD;
        end
        S_HALT: begin
          if (clear_fault) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Every output is decoded from the next state so it changes on the same
  // edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      timer             <= '0;
      start_driving     <= 1'b0;
      busy              <= 1'b0;
      fault             <= 1'b0;
      move_done         <= 1'b0;
      cmd_ready         <= 1'b1;
      stepper_step_in_1 <= '0;
      stepper_step_in_2 <= '0;
      stepper_speed_1   <= '0;
      stepper_speed_2   <= '0;
      residual_1        <= '0;
      residual_2        <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= (state == S_WAIT_RUN) ? timer + TMR_W'(1) : '0;
      start_driving <= (state_nxt == S_START) || (state_nxt == S_WAIT_RUN) ||
                       (state_nxt == S_RUN);
      busy          <= (state_nxt != S_IDLE);
      fault         <= (state_nxt == S_HALT);
      move_done     <= done;
      cmd_ready     <= (state_nxt != S_HALT) && (count_nxt != CNT_W'(DEPTH));
      if (load) begin
        stepper_step_in_1 <= head.steps_1;
        stepper_speed_1   <= head.speed_1;
        stepper_step_in_2 <= head.steps_2;
        stepper_speed_2   <= head.speed_2;
      end
      if (latch_res) begin
        residual_1 <= stepper_step_out_1;
        residual_2 <= stepper_step_out_2;
      end
    end
  end

endmodule

// File: tb/tb_corexy_move_sequencer.sv
// Bench for corexy_move_sequencer: pulse-generator model, move scoreboard
// checked on every move_done, and one task per scenario.
module tb_corexy_move_sequencer;

  localparam int DEPTH         = 4;
  localparam int START_TIMEOUT = 3;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_steps_1, cmd_speed_1, cmd_steps_2, cmd_speed_2;
  logic        abort;
  logic        clear_fault;
  logic [31:0] stepper_step_in_1, stepper_step_in_2;
  logic [31:0] stepper_speed_1, stepper_speed_2;
  logic        start_driving;
  logic        steppers_driving;
  logic [31:0] stepper_step_out_1, stepper_step_out_2;
  logic        busy;
  logic [2:0]  queue_count;
  logic        move_done;
  logic        fault;
  logic [31:0] residual_1, residual_2;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [127:0] exp_q[$];
  logic [127:0] sb_exp, sb_got;

  // pulse-generator model controls
  int          pg_len = 5;
  bit          pg_hold = 0;
  bit          pg_respond = 1;
  logic [30:0] pg_res_1 = '0;
  logic [30:0] pg_res_2 = '0;
  int          pg_phase = 0;
  int          pg_cnt = 0;
  bit          gap_active = 0;
  int          gap_cnt = 0;
  int          gap_q[$];

  corexy_move_sequencer #(
    .DEPTH         (DEPTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_steps_1        (cmd_steps_1),
    .cmd_speed_1        (cmd_speed_1),
    .cmd_steps_2        (cmd_steps_2),
    .cmd_speed_2        (cmd_speed_2),
    .abort              (abort),
    .clear_fault        (clear_fault),
    .stepper_step_in_1  (stepper_step_in_1),
    .stepper_step_in_2  (stepper_step_in_2),
    .stepper_speed_1    (stepper_speed_1),
    .stepper_speed_2    (stepper_speed_2),
    .start_driving      (start_driving),
    .steppers_driving   (steppers_driving),
    .stepper_step_out_1 (stepper_step_out_1),
    .stepper_step_out_2 (stepper_step_out_2),
    .busy               (busy),
    .queue_count        (queue_count),
    .move_done          (move_done),
    .fault              (fault),
    .residual_1         (residual_1),
    .residual_2         (residual_2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  // ---------------- pulse-generator model ----------------
  // Reacts 1ns after each edge: raises driving when start_driving is seen,
  // runs pg_len cycles (frozen while pg_hold), then drops with residuals.
  initial begin
    steppers_driving   = 1'b0;
    stepper_step_out_1 = '0;
    stepper_step_out_2 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (gap_active) begin
        gap_cnt++;
        if (start_driving) begin
          gap_q.push_back(gap_cnt);
          gap_active = 0;
        end
      end
      if (!rst_n) begin
        steppers_driving = 1'b0;
        pg_phase = 0;
      end else begin
        case (pg_phase)
          0: if (start_driving && pg_respond) begin
               steppers_driving   = 1'b1;
               stepper_step_out_1 = stepper_step_in_1;
               stepper_step_out_2 = stepper_step_in_2;
               pg_cnt   = 0;
               pg_phase = 1;
             end
          1: if (!start_driving) begin
               steppers_driving = 1'b0;
               pg_phase = 2;
             end else if (!pg_hold) begin
               pg_cnt++;
               if (pg_cnt >= pg_len) begin
                 steppers_driving   = 1'b0;
                 stepper_step_out_1 = {stepper_step_in_1[31], pg_res_1};
                 stepper_step_out_2 = {stepper_step_in_2[31], pg_res_2};
                 if (pg_res_1 == '0 && pg_res_2 == '0) begin
                   gap_active = 1;
                   gap_cnt    = 0;
                 end
                 pg_phase = 2;
               end
             end
          default: if (!start_driving) pg_phase = 0;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && move_done === 1'b1) begin
      done_cnt++;
      n_cmp++;
      sb_got = {stepper_step_in_1, stepper_speed_1, stepper_step_in_2, stepper_speed_2};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_move: move_done with no expected move, outputs=%h", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_err++;
          $display("FAIL sb_move: got %h expected %h", sb_got, sb_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_cmd(input logic [31:0] s1, input logic [31:0] p1,
                           input logic [31:0] s2, input logic [31:0] p2);
    int b = 0;
    while (cmd_ready !== 1'b1 && b < 200) begin
      cyc(1);
      b++;
    end
    if (cmd_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_cmd_ready: timed out, cmd_ready=%b required 1", cmd_ready);
    end else begin
      cmd_valid   = 1'b1;
      cmd_steps_1 = s1;
      cmd_speed_1 = p1;
      cmd_steps_2 = s2;
      cmd_speed_2 = p2;
      cyc(1);
      cmd_valid = 1'b0;
      exp_q.push_back({s1, p1, s2, p2});
    end
  endtask

  task automatic wait_driving(input logic lvl);
    int b = 0;
    while (steppers_driving !== lvl && b < 100) begin
      cyc(1);
      b++;
    end
    if (steppers_driving !== lvl) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_driving: timed out, steppers_driving=%b required %b", steppers_driving, lvl);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_cmp++;
    if ({cmd_ready, busy, fault, move_done, start_driving} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 10000", {cmd_ready, busy, fault, move_done, start_driving});
    end
    n_cmp++;
    if ({stepper_step_in_1, stepper_step_in_2, stepper_speed_1, stepper_speed_2,
         residual_1, residual_2, 3'(queue_count)} !== 195'd0) begin
      n_err++;
      $display("FAIL reset_words: nonzero data output or queue_count=%0d", queue_count);
    end
    rst_n = 1'b1;
    cyc(2);
    n_cmp++;
    if ({cmd_ready, busy, start_driving, queue_count} !== {3'b100, 3'd0}) begin
      n_err++;
      $display("FAIL reset_release_idle: got ready/busy/start=%b%b%b count=%0d required 100/0",
               cmd_ready, busy, start_driving, queue_count);
    end
  endtask

  task automatic test_single_move();
    int d0 = done_cnt;
    pg_len = 5; pg_hold = 0; pg_respond = 1; pg_res_1 = '0; pg_res_2 = '0;
    drive_cmd(32'd100, 32'd10, 32'h8000_0032, 32'd20);
    wait_driving(1'b1);
    wait_driving(1'b0);
    n_cmp++;
    if (start_driving !== 1'b1) begin
      n_err++;
      $display("FAIL single_start_held: start_driving=%b required 1 as driving falls", start_driving);
    end
    cyc(1);
    n_cmp++;
    if ({start_driving, move_done, busy} !== 3'b011) begin
      n_err++;
      $display("FAIL single_release: start/done/busy=%b required 011", {start_driving, move_done, busy});
    end
    cyc(1);
    n_cmp++;
    if ({start_driving, move_done, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL single_idle: start/done/busy=%b required 000", {start_driving, move_done, busy});
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL single_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_zero_move();
    int d0 = done_cnt;
    int seen = 0;
    int hi = 0;
    drive_cmd(32'd0, 32'd7, 32'h8000_0000, 32'd9);
    for (int i = 0; i < 6; i++) begin
      if (i < 3 && move_done === 1'b1) seen = 1;
      if (start_driving === 1'b1) hi++;
      cyc(1);
    end
    n_cmp++;
    if (seen !== 1) begin
      n_err++;
      $display("FAIL zero_done_latency: move_done seen=%0d required 1 within 3 cycles", seen);
    end
    n_cmp++;
    if (hi !== 0) begin
      n_err++;
      $display("FAIL zero_no_start: start_driving high %0d cycles required 0", hi);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_err++;
      $display("FAIL zero_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_start_timeout();
    int d0 = done_cnt;
    int hi = 0;
    pg_respond = 0;
    drive_cmd(32'd5, 32'd3, 32'd6, 32'd3);
    for (int i = 0; i < 12; i++) begin
      if (start_driving === 1'b1) hi++;
      cyc(1);
    end
    n_cmp++;
    if (hi !== START_TIMEOUT + 1) begin
      n_err++;
      $display("FAIL timeout_start_cycles: got %0d required %0d", hi, START_TIMEOUT + 1);
    end
    n_cmp++;
    if ({done_cnt - d0, busy} !== {32'd1, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_done: done=%0d busy=%b required 1/0", done_cnt - d0, busy);
    end
    pg_respond = 1;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int b = 0;
    pg_len = 4; pg_hold = 1;
    gap_q.delete();
    gap_active = 0;
    drive_cmd(32'd300, 32'd12, 32'd150, 32'd24);
    wait_driving(1'b1);
    cyc(2);
    for (int i = 0; i < 4; i++)
      drive_cmd({1'($urandom_range(0, 1)), 31'($urandom_range(1, 1000))}, $urandom_range(1, 50),
                {1'($urandom_range(0, 1)), 31'($urandom_range(1, 1000))}, $urandom_range(1, 50));
    n_cmp++;
    if ({queue_count, cmd_ready} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL full_flags: count=%0d ready=%b required 4/0", queue_count, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_steps_1 = 32'd77;
    cyc(2);
    cmd_valid = 1'b0;
    n_cmp++;
    if (queue_count !== 3'd4) begin
      n_err++;
      $display("FAIL full_offer_ignored: count=%0d required 4", queue_count);
    end
    pg_hold = 0;
    while (done_cnt - d0 < 5 && b < 400) begin
      cyc(1);
      b++;
    end
    cyc(2);
    n_cmp++;
    if ({done_cnt - d0, queue_count, busy} !== {32'd5, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_drain: done=%0d count=%0d busy=%b required 5/0/0", done_cnt - d0, queue_count, busy);
    end
    n_cmp++;
    if (gap_q.size() !== 4) begin
      n_err++;
      $display("FAIL b2b_gap_count: got %0d gaps required 4", gap_q.size());
    end
    foreach (gap_q[i]) begin
      n_cmp++;
      if (gap_q[i] !== 3) begin
        n_err++;
        $display("FAIL b2b_gap_%0d: got %0d cycles required 3", i, gap_q[i]);
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL sb_drained: %0d expected moves never completed, required 0", exp_q.size());
    end
  endtask

  task automatic test_endstop();
    int d0 = done_cnt;
    int b = 0;
    pg_len = 8; pg_hold = 0; pg_res_1 = 31'd40; pg_res_2 = '0;
    drive_cmd(32'd200, 32'd4, 32'h8000_0064, 32'd6);
    drive_cmd(32'd11, 32'd5, 32'd12, 32'd5);
    drive_cmd(32'd13, 32'd5, 32'd14, 32'd5);
    wait_driving(1'b1);
    n_cmp++;
    if (queue_count !== 3'd2) begin
      n_err++;
      $display("FAIL endstop_queued: count=%0d required 2", queue_count);
    end
    while (fault !== 1'b1 && b < 100) begin
      cyc(1);
      b++;
    end
    n_cmp++;
    if ({fault, cmd_ready, start_driving, queue_count} !== {3'b100, 3'd0}) begin
      n_err++;
      $display("FAIL endstop_halt: fault/ready/start=%b%b%b count=%0d required 100/0",
               fault, cmd_ready, start_driving, queue_count);
    end
    n_cmp++;
    if ({residual_1, residual_2} !== {32'd40, 32'h8000_0000}) begin
      n_err++;
      $display("FAIL endstop_residuals: got %h/%h required 00000028/80000000", residual_1, residual_2);
    end
    n_cmp++;
    if (done_cnt !== d0) begin
      n_err++;
      $display("FAIL endstop_no_done: got %0d move_done pulses required 0", done_cnt - d0);
    end
    exp_q.delete();
    clear_fault = 1'b1;
    cyc(1);
    clear_fault = 1'b0;
    n_cmp++;
    if ({fault, busy, cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL endstop_clear: fault/busy/ready=%b required 001", {fault, busy, cmd_ready});
    end
    n_cmp++;
    if (residual_1 !== 32'd40) begin
      n_err++;
      $display("FAIL residual_hold: got %h required 00000028", residual_1);
    end
    pg_res_1 = '0;
  endtask

  task automatic test_abort_run();
    int d0 = done_cnt;
    pg_len = 6; pg_hold = 1;
    drive_cmd(32'd500, 32'd8, 32'h8000_0100, 32'd8);
    wait_driving(1'b1);
    cyc(2);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_steps_1 = $urandom_range(1, 1000);
    cmd_speed_1 = 32'd3; cmd_steps_2 = 32'd9; cmd_speed_2 = 32'd3;
    cyc(1);
    abort = 1'b0;
    cmd_valid = 1'b0;
    n_cmp++;
    if ({start_driving, fault, cmd_ready, queue_count} !== {3'b010, 3'd0}) begin
      n_err++;
      $display("FAIL abort_halt: start/fault/ready=%b%b%b count=%0d required 010/0",
               start_driving, fault, cmd_ready, queue_count);
    end
    n_cmp++;
    if ({residual_1, residual_2} !== {32'd500, 32'h8000_0100}) begin
      n_err++;
      $display("FAIL abort_residuals: got %h/%h required 000001f4/80000100", residual_1, residual_2);
    end
    exp_q.delete();
    clear_fault = 1'b1;
    cyc(1);
    clear_fault = 1'b0;
    cyc(3);
    n_cmp++;
    if ({busy, start_driving, queue_count, done_cnt - d0} !== {2'b00, 3'd0, 32'd0}) begin
      n_err++;
      $display("FAIL abort_push_dropped: busy=%b start=%b count=%0d done=%0d required 0/0/0/0",
               busy, start_driving, queue_count, done_cnt - d0);
    end
    pg_hold = 0;
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_steps_1 = 32'd21; cmd_speed_1 = 32'd2; cmd_steps_2 = 32'd22; cmd_speed_2 = 32'd2;
    cyc(1);
    abort = 1'b0;
    cmd_valid = 1'b0;
    n_cmp++;
    if ({busy, fault, cmd_ready, queue_count} !== {3'b001, 3'd0}) begin
      n_err++;
      $display("FAIL abort_idle: busy/fault/ready=%b%b%b count=%0d required 001/0",
               busy, fault, cmd_ready, queue_count);
    end
    cyc(3);
    n_cmp++;
    if ({busy, start_driving} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_idle_stays: busy/start=%b required 00", {busy, start_driving});
    end
  endtask

  task automatic test_reset_mid_run();
    pg_len = 6; pg_hold = 1;
    drive_cmd(32'd900, 32'd5, 32'd901, 32'd5);
    wait_driving(1'b1);
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (start_driving !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_start: start_driving=%b required 0 before any edge", start_driving);
    end
    n_cmp++;
    if ({cmd_ready, busy, fault, move_done, queue_count, stepper_step_in_1, stepper_speed_2,
         residual_1, residual_2} !== {4'b1000, 3'd0, 128'd0}) begin
      n_err++;
      $display("FAIL reset_mid_run_values: ready/busy/fault/done=%b%b%b%b count=%0d step1=%h res1=%h",
               cmd_ready, busy, fault, move_done, queue_count, stepper_step_in_1, residual_1);
    end
    exp_q.delete();
    @(posedge clk);
    #2;
    cyc(1);
    rst_n = 1'b1;
    pg_hold = 0;
    cyc(2);
    n_cmp++;
    if ({busy, cmd_ready, start_driving} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_mid_run_idle: busy/ready/start=%b required 010", {busy, cmd_ready, start_driving});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps_1 = '0; cmd_speed_1 = '0; cmd_steps_2 = '0; cmd_speed_2 = '0;
    abort = 1'b0;
    clear_fault = 1'b0;
    #3;
    test_reset();
    test_single_move();
    test_zero_move();
    test_start_timeout();
    test_back_to_back();
    test_endstop();
    test_abort_run();
    test_abort_idle();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
